// File: rtl/cpu_pkg.sv
// ---------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the fetch/decode datapath: instruction width,
// opcode values, instruction field positions, the fetch FSM state type and
// a helper that sizes occupancy counters.
// ---------------------------------------------------------------------------
package cpu_pkg;

   localparam int INST_W = 16;

   // Opcodes understood by decode
   localparam logic [3:0] OP_ADD = 4'h0;
   localparam logic [3:0] OP_SUB = 4'h1;
   localparam logic [3:0] OP_LDI = 4'hf;

   // Instruction field positions: [15:12] op, [11:8] rd, [7:4] rs1,
   // [3:0] rs2, or [7:0] imm for immediate forms
   localparam int OPC_MSB = 15;
   localparam int OPC_LSB = 12;
   localparam int RD_MSB  = 11;
   localparam int RD_LSB  = 8;
   localparam int RS1_MSB = 7;
   localparam int RS1_LSB = 4;
   localparam int RS2_MSB = 3;
   localparam int RS2_LSB = 0;
   localparam int IMM_MSB = 7;
   localparam int IMM_LSB = 0;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } fetch_state_t;

   // Width of a counter able to hold the values 0..depth inclusive
   function automatic int cnt_width(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// ---------------------------------------------------------------------------
// fetch_unit_if
// Bundles the instruction-memory read port, the instruction handshake toward
// decode and the redirect request.
//   master : fetch unit side (drives mem_req/mem_addr and inst_*)
//   slave  : environment side (memory, decode and branch logic)
// ---------------------------------------------------------------------------
interface fetch_unit_if #(
   parameter int ADDR_W = 8
);
   import cpu_pkg::*;

   // instruction memory read port
   logic                mem_req;
   logic [ADDR_W-1:0]   mem_addr;
   logic                mem_ready;
   logic                mem_rvalid;
   logic [INST_W-1:0]   mem_rdata;

   // instruction stream toward decode
   logic                inst_valid;
   logic [INST_W-1:0]   inst;
   logic [ADDR_W-1:0]   inst_pc;
   logic                inst_ready;

   // control flow change
   logic                redirect;
   logic [ADDR_W-1:0]   redirect_pc;

   modport master (
      output mem_req, mem_addr,
      input  mem_ready, mem_rvalid, mem_rdata,
      output inst_valid, inst, inst_pc,
      input  inst_ready,
      input  redirect, redirect_pc
   );

   modport slave (
      input  mem_req, mem_addr,
      output mem_ready, mem_rvalid, mem_rdata,
      input  inst_valid, inst, inst_pc,
      output inst_ready,
      output redirect, redirect_pc
   );

endinterface

// File: rtl/fetch_fifo.sv
// ---------------------------------------------------------------------------
// fetch_fifo
// Synchronous prefetch FIFO holding {instruction, pc} entries.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   push/wdata : write an entry (ignored when full unless a pop frees a slot)
//   pop        : remove the head entry (ignored when empty)
//   flush      : drop all entries; overrides push and pop
//   rdata      : head entry, read straight from registered storage
//   count      : current occupancy (0..DEPTH)
//   empty      : occupancy is zero
// ---------------------------------------------------------------------------
module fetch_fifo
   import cpu_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int WIDTH = 24,
   localparam int CW   = cnt_width(DEPTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic             pop,
   input  logic             flush,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] rdata,
   output logic [CW-1:0]    count,
   output logic             empty
);
   localparam int PW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_reg [DEPTH];
   logic [PW-1:0]    wr_ptr_reg;
   logic [PW-1:0]    rd_ptr_reg;
   logic [CW-1:0]    count_reg;
   logic             full;
   logic             push_eff;
   logic             pop_eff;

   assign full     = (count_reg == CW'(DEPTH));
   assign empty    = (count_reg == '0);
   assign pop_eff  = pop & ~flush & ~empty;
   // a pop in the same cycle frees the slot a push on a full FIFO needs
   assign push_eff = push & ~flush & (~full | pop_eff);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else if (flush) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (push_eff) begin
            wr_ptr_reg <= wr_ptr_reg + PW'(1);
         end
         if (pop_eff) begin
            rd_ptr_reg <= rd_ptr_reg + PW'(1);
         end
         count_reg <= count_reg + CW'(push_eff) - CW'(pop_eff);
      end
   end

   // Storage is cleared on reset so the head reads as zero until written
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_reg[i] <= '0;
         end
      end else if (push_eff) begin
         mem_reg[wr_ptr_reg] <= wdata;
      end
   end

   assign rdata = mem_reg[rd_ptr_reg];
   assign count = count_reg;

endmodule

// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit
// Instruction fetch stage: keeps the fetch PC, issues word reads to
// instruction memory, buffers returned instructions with their PC in a
// prefetch FIFO and hands them to decode over a valid/ready handshake.
// A redirect flushes the FIFO and discards responses still in flight.
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   en    : fetch enable (IDLE <-> RUN)
//   bus   : fetch_unit_if master -- memory port, inst handshake, redirect
// ---------------------------------------------------------------------------
module fetch_unit
   import cpu_pkg::*;
#(
   parameter int                ADDR_W   = 8,
   parameter int                DEPTH    = 4,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         en,
   fetch_unit_if.master bus
);
   localparam int CW = cnt_width(DEPTH);
   localparam int EW = INST_W + ADDR_W;

   fetch_state_t      state_reg;
   fetch_state_t      state_next;
   logic [ADDR_W-1:0] fetch_pc_reg;
   logic [ADDR_W-1:0] resp_pc_reg;
   logic [CW-1:0]     outstanding_reg;
   logic [CW-1:0]     discard_reg;

   logic [CW-1:0]     fifo_count;
   logic              fifo_empty;
   logic [EW-1:0]     fifo_rdata;
   logic [CW:0]       in_use;
   logic              mem_req;
   logic              inst_valid;
   logic              accept;
   logic              push;
   logic              pop;

   // ---------------- FSM: state register ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (en)  state_next = RUN;
         RUN:     if (!en) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // ---------------- FSM: outputs ----------------
   // Buffered plus in-flight entries may never exceed the FIFO depth, so
   // every response is guaranteed a slot without memory backpressure.
   assign in_use = {1'b0, fifo_count} + {1'b0, outstanding_reg};

   always_comb begin
      mem_req    = 1'b0;
      inst_valid = 1'b0;
      if ((state_reg == RUN) && !bus.redirect && (in_use < (CW+1)'(DEPTH))) begin
         mem_req = 1'b1;
      end
      inst_valid = !fifo_empty && !bus.redirect;
   end

   assign accept = mem_req & bus.mem_ready;
   // responses to requests issued before a redirect are dropped, as is
   // anything arriving during the redirect cycle itself
   assign push   = bus.mem_rvalid & ~bus.redirect & (discard_reg == '0);
   assign pop    = inst_valid & bus.inst_ready;

   // ---------------- PC and in-flight bookkeeping ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fetch_pc_reg    <= RESET_PC;
         resp_pc_reg     <= RESET_PC;
         outstanding_reg <= '0;
         discard_reg     <= '0;
      end else if (bus.redirect) begin
         // no request is issued this cycle; everything still in flight
         // after this cycle's response becomes stale
         fetch_pc_reg    <= bus.redirect_pc;
         resp_pc_reg     <= bus.redirect_pc;
         outstanding_reg <= outstanding_reg - CW'(bus.mem_rvalid);
         discard_reg     <= outstanding_reg - CW'(bus.mem_rvalid);
      end else begin
         if (accept) begin
            fetch_pc_reg <= fetch_pc_reg + ADDR_W'(1);
         end
         outstanding_reg <= outstanding_reg + CW'(accept) - CW'(bus.mem_rvalid);
         if (bus.mem_rvalid) begin
            if (discard_reg != '0) begin
               discard_reg <= discard_reg - CW'(1);
            end else begin
               resp_pc_reg <= resp_pc_reg + ADDR_W'(1);
            end
         end
      end
   end

   // ---------------- prefetch buffer ----------------
   fetch_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (EW)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push),
      .pop   (pop),
      .flush (bus.redirect),
      .wdata ({bus.mem_rdata, resp_pc_reg}),
      .rdata (fifo_rdata),
      .count (fifo_count),
      .empty (fifo_empty)
   );

   assign bus.mem_req    = mem_req;
   assign bus.mem_addr   = fetch_pc_reg;
   assign bus.inst_valid = inst_valid;
   assign bus.inst       = fifo_rdata[EW-1:ADDR_W];
   assign bus.inst_pc    = fifo_rdata[ADDR_W-1:0];

endmodule

// File: tb/tb_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_fetch_unit
// Self-checking bench for fetch_unit. dut0 (RESET_PC=0) runs against a
// memory model with configurable latency and optional mem_ready toggling;
// dut1 (RESET_PC=8'hfe) runs against a zero-wait memory to show PC wrap.
// Memory returns 16'hf000 | address.
// ---------------------------------------------------------------------------
module tb_fetch_unit;
   import cpu_pkg::*;

   localparam int AW = 8;

   logic clk = 1'b0;
   logic rst_n;
   logic en;

   always #5 clk = ~clk;

   fetch_unit_if #(.ADDR_W(AW)) bus0 ();
   fetch_unit_if #(.ADDR_W(AW)) bus1 ();

   fetch_unit #(.ADDR_W(AW), .DEPTH(4), .RESET_PC(8'h00)) dut0 (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (en),
      .bus   (bus0)
   );

   fetch_unit #(.ADDR_W(AW), .DEPTH(4), .RESET_PC(8'hfe)) dut1 (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (en),
      .bus   (bus1)
   );

   int tests = 0;
   int fails = 0;

   typedef struct {
      logic [AW-1:0] pc;
      logic [15:0]   inst;
      int            cyc;
   } deliv_t;

   typedef struct {
      logic [AW-1:0] addr;
      int            cyc;
   } req_t;

   deliv_t        dlog0[$];
   deliv_t        dlog1[$];
   req_t          rlog0[$];
   logic [AW-1:0] pend_addr[$];
   int            pend_due[$];
   int            cyc     = 0;
   int            lat     = 1;
   bit            toggle  = 1'b0;
   int            max_out = 0;

   // ---------------- dut0 memory model + monitors ----------------
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend_addr.delete();
         pend_due.delete();
         bus0.mem_rvalid <= 1'b0;
         bus0.mem_rdata  <= 16'h0000;
         bus0.mem_ready  <= 1'b1;
      end else begin
         if (pend_addr.size() + int'(bus0.mem_rvalid) > max_out)
            max_out = pend_addr.size() + int'(bus0.mem_rvalid);
         if (bus0.mem_req && bus0.mem_ready) begin
            pend_addr.push_back(bus0.mem_addr);
            pend_due.push_back(cyc + lat);
            rlog0.push_back('{bus0.mem_addr, cyc});
         end
         if (bus0.inst_valid && bus0.inst_ready)
            dlog0.push_back('{bus0.inst_pc, bus0.inst, cyc});
         if (pend_due.size() > 0 && pend_due[0] == cyc + 1) begin
            bus0.mem_rvalid <= 1'b1;
            bus0.mem_rdata  <= 16'hf000 | {8'h00, pend_addr[0]};
            void'(pend_addr.pop_front());
            void'(pend_due.pop_front());
         end else begin
            bus0.mem_rvalid <= 1'b0;
         end
         bus0.mem_ready <= toggle ? ~bus0.mem_ready : 1'b1;
         cyc <= cyc + 1;
      end
   end

   // ---------------- dut1 zero-wait memory + monitor ----------------
   assign bus1.mem_ready   = 1'b1;
   assign bus1.inst_ready  = 1'b1;
   assign bus1.redirect    = 1'b0;
   assign bus1.redirect_pc = 8'h00;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus1.mem_rvalid <= 1'b0;
         bus1.mem_rdata  <= 16'h0000;
      end else begin
         bus1.mem_rvalid <= bus1.mem_req & bus1.mem_ready;
         bus1.mem_rdata  <= 16'hf000 | {8'h00, bus1.mem_addr};
         if (bus1.inst_valid)
            dlog1.push_back('{bus1.inst_pc, bus1.inst, 0});
      end
   end

   // ---------------- helpers ----------------
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end else begin
         $display("ok   %s: %h", name, act);
      end
   endtask

   task automatic do_reset(input int l, input bit t);
      @(negedge clk);
      rst_n = 1'b0;
      en    = 1'b0;
      bus0.redirect   = 1'b0;
      bus0.inst_ready = 1'b1;
      lat    = l;
      toggle = t;
      repeat (2) @(negedge clk);
      dlog0.delete();
      dlog1.delete();
      rlog0.delete();
      max_out = 0;
      rst_n = 1'b1;
   endtask

   // every delivered entry must continue the sequence from start_pc
   task automatic check_seq(input string name, input logic [AW-1:0] start_pc, input int nmin);
      logic [AW-1:0] pc;
      chk({name, " count>=min"}, 32'(dlog0.size() >= nmin), 32'd1);
      pc = start_pc;
      for (int i = 0; i < dlog0.size(); i++) begin
         chk($sformatf("%s pc[%0d]", name, i), 32'(dlog0[i].pc), 32'(pc));
         chk($sformatf("%s inst[%0d]", name, i), 32'(dlog0[i].inst), 32'(16'hf000 | {8'h00, pc}));
         pc = pc + 8'd1;
      end
   endtask

   typedef struct {
      bit            en;
      bit            rdy;
      bit            req;
      logic [AW-1:0] addr;
      bit            vld;
      logic [AW-1:0] pc;
      logic [15:0]   inst;
   } vec_t;

   vec_t vecs[7];

   initial begin
      int t_redir;
      int n_before;
      int first_new;

      rst_n = 1'b0;
      en    = 1'b0;
      bus0.inst_ready  = 1'b1;
      bus0.redirect    = 1'b0;
      bus0.redirect_pc = 8'h00;

      // inputs applied at a negedge, outputs expected at the following negedge
      vecs[0] = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 16'h0000};
      vecs[1] = '{1'b1, 1'b1, 1'b1, 8'h00, 1'b0, 8'h00, 16'h0000};
      vecs[2] = '{1'b1, 1'b1, 1'b1, 8'h01, 1'b0, 8'h00, 16'h0000};
      vecs[3] = '{1'b1, 1'b1, 1'b1, 8'h02, 1'b1, 8'h00, 16'hf000};
      vecs[4] = '{1'b1, 1'b1, 1'b1, 8'h03, 1'b1, 8'h01, 16'hf001};
      vecs[5] = '{1'b1, 1'b1, 1'b1, 8'h04, 1'b1, 8'h02, 16'hf002};
      vecs[6] = '{1'b1, 1'b1, 1'b1, 8'h05, 1'b1, 8'h03, 16'hf003};

      // ---- reset state ----
      repeat (3) @(negedge clk);
      chk("reset mem_req", 32'(bus0.mem_req), 32'd0);
      chk("reset inst_valid", 32'(bus0.inst_valid), 32'd0);
      chk("reset inst", 32'(bus0.inst), 32'd0);
      chk("reset inst_pc", 32'(bus0.inst_pc), 32'd0);
      chk("reset dut1 mem_req", 32'(bus1.mem_req), 32'd0);

      // ---- zero-wait streaming, table driven ----
      do_reset(1, 1'b0);
      for (int i = 0; i < 7; i++) begin
         en = vecs[i].en;
         bus0.inst_ready = vecs[i].rdy;
         @(negedge clk);
         chk($sformatf("vec%0d mem_req", i), 32'(bus0.mem_req), 32'(vecs[i].req));
         if (vecs[i].req)
            chk($sformatf("vec%0d mem_addr", i), 32'(bus0.mem_addr), 32'(vecs[i].addr));
         chk($sformatf("vec%0d inst_valid", i), 32'(bus0.inst_valid), 32'(vecs[i].vld));
         chk($sformatf("vec%0d inst_pc", i), 32'(bus0.inst_pc), 32'(vecs[i].pc));
         chk($sformatf("vec%0d inst", i), 32'(bus0.inst), 32'(vecs[i].inst));
      end

      // ---- RESET_PC = fe wraps ----
      repeat (2) @(negedge clk);
      chk("wrap count>=4", 32'(dlog1.size() >= 4), 32'd1);
      if (dlog1.size() >= 4) begin
         chk("wrap pc0", 32'(dlog1[0].pc), 32'h fe);
         chk("wrap pc1", 32'(dlog1[1].pc), 32'h ff);
         chk("wrap pc2", 32'(dlog1[2].pc), 32'h 00);
         chk("wrap pc3", 32'(dlog1[3].pc), 32'h 01);
         chk("wrap inst0", 32'(dlog1[0].inst), 32'h f0fe);
         chk("wrap inst2", 32'(dlog1[2].inst), 32'h f000);
      end

      // ---- backpressure: decode stalled ----
      do_reset(1, 1'b0);
      bus0.inst_ready = 1'b0;
      en = 1'b1;
      repeat (12) @(negedge clk);
      chk("stall requests", 32'(rlog0.size()), 32'd4);
      chk("stall mem_req", 32'(bus0.mem_req), 32'd0);
      chk("stall inst_valid", 32'(bus0.inst_valid), 32'd1);
      chk("stall head pc", 32'(bus0.inst_pc), 32'd0);
      chk("stall delivered", 32'(dlog0.size()), 32'd0);
      bus0.inst_ready = 1'b1;
      repeat (12) @(negedge clk);
      check_seq("release", 8'h00, 8);
      chk("release max_out<=4", 32'(max_out <= 4), 32'd1);

      // ---- slow memory: latency 3, mem_ready toggling ----
      do_reset(3, 1'b1);
      en = 1'b1;
      repeat (60) @(negedge clk);
      check_seq("slowmem", 8'h00, 8);
      chk("slowmem max_out<=4", 32'(max_out <= 4), 32'd1);

      // ---- redirect with two requests in flight ----
      do_reset(3, 1'b0);
      en = 1'b1;
      repeat (3) @(negedge clk);
      bus0.redirect    = 1'b1;
      bus0.redirect_pc = 8'h40;
      t_redir = cyc;
      @(negedge clk);
      bus0.redirect = 1'b0;
      repeat (14) @(negedge clk);
      n_before = 0;
      first_new = -1;
      for (int i = 0; i < rlog0.size(); i++) begin
         if (rlog0[i].cyc < t_redir) n_before++;
         else if (first_new < 0) first_new = i;
      end
      chk("redir in-flight", 32'(n_before), 32'd2);
      chk("redir new req found", 32'(first_new >= 0), 32'd1);
      if (first_new >= 0) begin
         chk("redir new req addr", 32'(rlog0[first_new].addr), 32'h40);
         chk("redir new req cycle", 32'(rlog0[first_new].cyc - t_redir), 32'd1);
      end
      check_seq("redir", 8'h40, 4);

      // ---- asynchronous reset mid-stream ----
      @(negedge clk);
      chk("pre-reset inst_valid", 32'(bus0.inst_valid), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("async rst mem_req", 32'(bus0.mem_req), 32'd0);
      chk("async rst inst_valid", 32'(bus0.inst_valid), 32'd0);
      chk("async rst inst", 32'(bus0.inst), 32'd0);
      chk("async rst inst_pc", 32'(bus0.inst_pc), 32'd0);
      dlog0.delete();
      rlog0.delete();
      max_out = 0;
      lat = 1;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (10) @(negedge clk);
      chk("restart req seen", 32'(rlog0.size() > 0), 32'd1);
      if (rlog0.size() > 0)
         chk("restart first addr", 32'(rlog0[0].addr), 32'h00);
      check_seq("restart", 8'h00, 4);

      // ---- zero-wait redirect timing ----
      bus0.redirect    = 1'b1;
      bus0.redirect_pc = 8'h80;
      t_redir = cyc;
      @(negedge clk);
      bus0.redirect = 1'b0;
      repeat (8) @(negedge clk);
      first_new = -1;
      for (int i = 0; i < rlog0.size(); i++)
         if (rlog0[i].cyc > t_redir && first_new < 0) first_new = i;
      chk("zw redir req found", 32'(first_new >= 0), 32'd1);
      if (first_new >= 0) begin
         chk("zw redir req addr", 32'(rlog0[first_new].addr), 32'h80);
         chk("zw redir req cycle", 32'(rlog0[first_new].cyc - t_redir), 32'd1);
      end
      first_new = -1;
      for (int i = 0; i < dlog0.size(); i++)
         if (dlog0[i].cyc >= t_redir && first_new < 0) first_new = i;
      chk("zw redir inst found", 32'(first_new >= 0), 32'd1);
      if (first_new >= 0) begin
         chk("zw redir inst pc", 32'(dlog0[first_new].pc), 32'h80);
         chk("zw redir inst cycle", 32'(dlog0[first_new].cyc - t_redir), 32'd3);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
